debouncer_multi: RTL and testbench
==================================

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter clock_freq, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter debounce_time, default 1000, required stable time in microseconds.
REQ-003 SHALL have parameter initial_value, default 1'b0, reset level of every channel.
REQ-004 SHALL have parameter channels, default 4, number of independent inputs (1..32).
REQ-005 SHALL have parameter long_press_time, default 1000, long-press threshold in milliseconds.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-008 SHALL have port signal_i, input, channels, raw asynchronous bouncing inputs.
REQ-009 SHALL have port en_i, input, channels, per-channel enable.
REQ-010 SHALL have port signal_o, output, channels, debounced levels.
REQ-011 SHALL have port rise_o, output, channels, one-cycle pulse on a debounced 0->1 transition.
REQ-012 SHALL have port fall_o, output, channels, one-cycle pulse on a debounced 1->0 transition.
REQ-013 SHALL have port long_o, output, channels, one-cycle long-press pulse.

Function
REQ-014 SHALL pass each signal_i bit through a 2-flop synchronizer before any use.
REQ-015 SHALL derive DB_CYCLES = (clock_freq/1_000_000)*debounce_time and LP_CYCLES = (clock_freq/1000)*long_press_time.
REQ-016 SHALL size counters as $clog2(cycles+1) bits and never wrap; saturate at threshold.
REQ-017 SHALL, per channel, increment its counter each cycle the synchronized input differs from signal_o, and clear it the cycle it matches.
REQ-018 SHALL toggle signal_o and clear the counter on the cycle after the counter reaches DB_CYCLES-1 while still differing.
REQ-019 SHALL give a latency of exactly 2+DB_CYCLES clocks from a clean input edge to the signal_o change.
REQ-020 SHALL assert rise_o/fall_o in the same cycle signal_o changes, for exactly one cycle.
REQ-021 SHALL, when en_i is low, hold signal_o, clear both counters, and keep rise_o/fall_o/long_o low.
REQ-022 SHALL, on en_i rising, restart qualification from zero count; no edge is reported for changes made while disabled until they are re-qualified.
REQ-023 SHALL keep channels fully independent; simultaneous events on multiple channels are all reported in the same cycle.
REQ-024 SHALL treat a bounce shorter than DB_CYCLES as glitch: no output change, no pulse.

Reset
REQ-025 SHALL, on rst_n low, set synchronizers and signal_o to initial_value and all counters and pulse outputs to 0, immediately and independently of clk.
REQ-026 SHALL, on reset mid-qualification, discard partial counts; deassertion is synchronized to clk internally.

Configuration
REQ-027 SHALL compile long-press logic only when macro DEBOUNCER_LONG_PRESS_EN is defined.
REQ-028 SHALL, with DEBOUNCER_LONG_PRESS_EN defined, count cycles signal_o stays 1 and pulse long_o once per press when the count reaches LP_CYCLES, with no repeat until signal_o falls.
REQ-029 SHALL, without DEBOUNCER_LONG_PRESS_EN, keep port long_o and drive it constant 0, with no long-press counter.

Structure
REQ-030 SHALL place the cycle-count function, counter-width function and channel-limit constants in package debouncer_pkg.
REQ-031 SHALL implement one channel in sub-module debounce_channel (synchronizer, counter, edge, long-press) and instantiate it channels times via generate.
REQ-032 SHALL raise an elaboration error if DB_CYCLES < 2 or channels outside 1..32.

Verification (clock_freq=100_000_000, debounce_time=10, long_press_time=1, channels=4)
REQ-033 SHALL test clean edge: ch0 0->1 held 20 us -> signal_o[0]=1 exactly 1002 clocks later, rise_o[0] one-cycle pulse, other channels unchanged.
REQ-034 SHALL test glitch: ch1 pulses high for 5 us then 3 us low, repeated 4 times, then low -> signal_o[1] stays 0, no rise_o/fall_o.
REQ-035 SHALL test simultaneous events: ch2 and ch3 rise in the same cycle -> both rise_o bits asserted in the same clock.
REQ-036 SHALL test enable: en_i[0]=0, ch0 toggles then holds 20 us -> no change; en_i[0]=1 -> change after 1000 more clocks.
REQ-037 SHALL test long press: ch0 held 2 ms -> long_o[0] one pulse at 100_000 clocks after rise_o; no pulse without the macro.
REQ-038 SHALL test reset: rst_n low mid-count (500 clocks) -> outputs equal initial_value at once; after release a full 1002-clock qualification is required.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel debouncer.
package debouncer_pkg;

    localparam int CHANNELS_MIN  = 1;
    localparam int CHANNELS_MAX  = 32;
    localparam int DB_CYCLES_MIN = 2;

    // Converts a time in (1/units_per_s) seconds into clock cycles.
    function automatic int cycles_from_time(input int clk_hz, input int units_per_s, input int t);
        longint c;
        c = longint'(clk_hz / units_per_s) * longint'(t);
        return int'(c);
    endfunction

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, stability counter, edge pulses and,
// with DEBOUNCER_LONG_PRESS_EN defined, a long-press detector.
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int   DB_CYCLES = 1000,
    parameter logic INIT      = 1'b0
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    parameter int   LP_CYCLES = 1000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_raw,
    input  logic en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int               DB_W    = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt;
    logic            differ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{INIT}};
        else        sync_q <= {sync_q[0], sig_raw};
    end

    assign differ = sync_q[1] ^ level;

    // The counter tops out at DB_LAST: reaching it while still differing flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= INIT;
            db_cnt <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en || !differ) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= ~level;
                db_cnt <= '0;
                rise   <= ~level;
                fall   <= level;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam int              LP_W    = cnt_width(LP_CYCLES);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt;

    // Saturating at LP_MAX suppresses repeat pulses until the level drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt     <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!en || !level) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_MAX) begin
                lp_cnt <= lp_cnt + LP_W'(1);
                if (lp_cnt == LP_LAST) long_press <= 1'b1;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer with edge pulses; long-press pulses are built
// only when DEBOUNCER_LONG_PRESS_EN is defined (otherwise long_o is tied low).
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int   clock_freq      = 100_000_000,
    parameter int   debounce_time   = 1000,
    parameter logic initial_value   = 1'b0,
    parameter int   channels        = 4,
    parameter int   long_press_time = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [channels-1:0] signal_i,
    input  logic [channels-1:0] en_i,
    output logic [channels-1:0] signal_o,
    output logic [channels-1:0] rise_o,
    output logic [channels-1:0] fall_o,
    output logic [channels-1:0] long_o
);

    localparam int DB_CYCLES = cycles_from_time(clock_freq, 1_000_000, debounce_time);
    localparam int LP_CYCLES = cycles_from_time(clock_freq, 1_000, long_press_time);

    if (channels < CHANNELS_MIN || channels > CHANNELS_MAX) begin : g_bad_channels
        $error("debouncer_multi: channels=%0d outside %0d..%0d", channels, CHANNELS_MIN, CHANNELS_MAX);
    end
    if (DB_CYCLES < DB_CYCLES_MIN) begin : g_bad_db
        $error("debouncer_multi: DB_CYCLES=%0d below %0d", DB_CYCLES, DB_CYCLES_MIN);
    end
    if (LP_CYCLES < 1) begin : g_bad_lp
        $error("debouncer_multi: LP_CYCLES=%0d must be at least 1", LP_CYCLES);
    end

    // Reset asserts asynchronously but releases two clocks later, aligned to clk.
    logic [1:0] rst_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end

    assign rst_int_n = rst_q[1];

    for (genvar i = 0; i < channels; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .INIT      (initial_value)
`ifdef DEBOUNCER_LONG_PRESS_EN
            ,
            .LP_CYCLES (LP_CYCLES)
`endif
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_int_n),
            .sig_raw    (signal_i[i]),
            .en         (en_i[i]),
            .level      (signal_o[i]),
            .rise       (rise_o[i]),
            .fall       (fall_o[i]),
            .long_press (long_o[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi at 100 MHz, 10 us debounce, 1 ms long press, 4 channels.
module tb_debouncer_multi;

    localparam int CH       = 4;
    localparam int DB       = 1000;
    localparam int LAT      = DB + 2;
    localparam int LP       = 100_000;
    localparam int RST_SYNC = 2;
    localparam int W        = 44;
    localparam logic INIT   = 1'b0;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] signal_i = '0;
    logic [CH-1:0] en_i = '1;
    logic [CH-1:0] signal_o, rise_o, fall_o, long_o;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [W-1:0] exp_q[$];

    debouncer_multi #(
        .clock_freq      (100_000_000),
        .debounce_time   (10),
        .initial_value   (INIT),
        .channels        (CH),
        .long_press_time (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .signal_i (signal_i),
        .en_i     (en_i),
        .signal_o (signal_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .long_o   (long_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    // Event word: {rise mask, fall mask, long mask, cycle of the edge that produced it}.
    function automatic logic [W-1:0] ev(input logic [3:0] r, input logic [3:0] f,
                                        input logic [3:0] l, input int unsigned c);
        return {r, f, l, c};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if ((rise_o | fall_o | long_o) != '0) begin
            if (exp_q.size() == 0) check_eq("unexpected_event", ev(rise_o, fall_o, long_o, cyc), '0);
            else                   check_eq("event", ev(rise_o, fall_o, long_o, cyc), exp_q.pop_front());
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_eq("reset_outputs", {signal_o, rise_o, fall_o, long_o}, {{CH{INIT}}, 12'h000});
        tick(2);
        rst_n = 1'b1;
        tick(10);

        // clean rising edge on ch0 with exact latency
        signal_i[0] = 1'b1;
        exp_q.push_back(ev(4'b0001, 4'b0000, 4'b0000, cyc + LAT));
        tick(LAT - 1);
        check_eq("clean_before", signal_o, 4'b0000);
        tick(1);
        check_eq("clean_after", signal_o, 4'b0001);
        check_eq("clean_rise", rise_o, 4'b0001);
        tick(1);
        check_eq("clean_rise_once", rise_o, 4'b0000);
        tick(100);

        // bouncing ch1 never qualifies
        for (int k = 0; k < 4; k++) begin
            signal_i[1] = 1'b1;
            tick(500);
            signal_i[1] = 1'b0;
            tick(300);
        end
        tick(LAT + 100);
        check_eq("glitch_level", signal_o, 4'b0001);

        // simultaneous rise then fall on ch2/ch3
        signal_i = signal_i | 4'b1100;
        exp_q.push_back(ev(4'b1100, 4'b0000, 4'b0000, cyc + LAT));
        tick(LAT + 10);
        check_eq("simul_rise_level", signal_o, 4'b1101);
        signal_i = signal_i & 4'b0011;
        exp_q.push_back(ev(4'b0000, 4'b1100, 4'b0000, cyc + LAT));
        tick(LAT + 10);
        check_eq("simul_fall_level", signal_o, 4'b0001);

        // disabled channel ignores changes, re-qualifies from zero after enable
        en_i[0] = 1'b0;
        signal_i[0] = 1'b0;
        tick(100);
        signal_i[0] = 1'b1;
        tick(100);
        signal_i[0] = 1'b0;
        tick(2000);
        check_eq("en_hold", signal_o, 4'b0001);
        en_i[0] = 1'b1;
        exp_q.push_back(ev(4'b0000, 4'b0001, 4'b0000, cyc + DB));
        tick(DB - 1);
        check_eq("en_before", signal_o, 4'b0001);
        tick(1);
        check_eq("en_after", signal_o, 4'b0000);
        tick(100);

        // long press on ch0
        signal_i[0] = 1'b1;
        exp_q.push_back(ev(4'b0001, 4'b0000, 4'b0000, cyc + LAT));
`ifdef DEBOUNCER_LONG_PRESS_EN
        exp_q.push_back(ev(4'b0000, 4'b0000, 4'b0001, cyc + LAT + LP));
        tick(LAT + LP + 500);
`else
        tick(LAT + 3000);
`endif
        check_eq("long_level", signal_o, 4'b0001);
        signal_i[0] = 1'b0;
        exp_q.push_back(ev(4'b0000, 4'b0001, 4'b0000, cyc + LAT));
        tick(LAT + 10);
        check_eq("long_release", signal_o, 4'b0000);

        // reset mid-qualification: ch2 qualified, ch1 halfway
        signal_i[2] = 1'b1;
        exp_q.push_back(ev(4'b0100, 4'b0000, 4'b0000, cyc + LAT));
        tick(LAT + 10);
        check_eq("pre_reset_level", signal_o, 4'b0100);
        signal_i[1] = 1'b1;
        tick(500);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", {signal_o, rise_o, fall_o, long_o}, {{CH{INIT}}, 12'h000});
        tick(5);
        rst_n = 1'b1;
        exp_q.push_back(ev(4'b0110, 4'b0000, 4'b0000, cyc + RST_SYNC + LAT));
        tick(RST_SYNC + LAT - 1);
        check_eq("requal_before", signal_o, 4'b0000);
        tick(1);
        check_eq("requal_after", signal_o, 4'b0110);
        tick(20);

        check_eq("exp_q_empty", exp_q.size(), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
